// File: rtl/sd_multiply_lo.sv
// Four-channel ADC x LO quadrature multiplier with turn-synchronous
// LO phase tracking and circular / single-pass window strobes.
module sd_multiply_lo #(
    parameter int ADC_WIDTH        = 16,
    parameter int LO_WIDTH         = 18,
    parameter int PRODUCT_WIDTH    = 24,
    parameter int SAMPLES_PER_TURN = 81
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [4*ADC_WIDTH-1:0]              adcData,
    input  logic                                turnMarker,
    input  logic                                singlePass,
    input  logic                                trigger,
    input  logic [7:0]                          turnsPerSum,
    input  logic [15:0]                         acqSamples,
    input  logic                                loWrite,
    input  logic [$clog2(SAMPLES_PER_TURN)-1:0] loAddr,
    input  logic [LO_WIDTH-1:0]                 loCos,
    input  logic [LO_WIDTH-1:0]                 loSin,
    input  logic                                markerClear,
    output logic [8*PRODUCT_WIDTH-1:0]          products,
    output logic                                loadEnable,
    output logic                                latchEnable,
    output logic                                markerError
);

    localparam int AW     = $clog2(SAMPLES_PER_TURN);
    localparam int FULL   = ADC_WIDTH + LO_WIDTH;
    localparam int D      = FULL - PRODUCT_WIDTH;
    localparam int RND_SH = (D > 0) ? D - 1 : 0;
    localparam logic signed [FULL-1:0] RND =
        (D > 0) ? (FULL'(1) << RND_SH) : '0;
    localparam logic [AW:0] ADDR_LIM = (AW + 1)'(SAMPLES_PER_TURN);
    localparam logic [AW-1:0] LAST_ADDR = AW'(SAMPLES_PER_TURN - 1);

    if (PRODUCT_WIDTH > FULL) begin : g_width_check
        $error("PRODUCT_WIDTH exceeds ADC_WIDTH+LO_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, ARMED, ACQUIRE, LATCH} state_t;

    state_t                   state;
    logic [AW-1:0]            phase;
    logic [AW-1:0]            rd_addr;
    logic                     seen_marker;
    logic [7:0]               turn_cnt;
    logic [15:0]              acq_cnt;
    logic                     circ_first;
    logic [7:0]               tps_last;
    logic [15:0]              acq_last;
    logic                     addr_ok;

    logic [LO_WIDTH-1:0]      cos_ram [SAMPLES_PER_TURN];
    logic [LO_WIDTH-1:0]      sin_ram [SAMPLES_PER_TURN];

    logic [4*ADC_WIDTH-1:0]   s1_adc;
    logic [LO_WIDTH-1:0]      s1_cos;
    logic [LO_WIDTH-1:0]      s1_sin;
    logic                     s1_load;
    logic                     s1_latch;
    logic [8*PRODUCT_WIDTH-1:0] s2_prod;
    logic                     s2_load;
    logic                     s2_latch;

    assign rd_addr  = turnMarker ? '0 : phase;
    assign tps_last = (turnsPerSum == 8'd0) ? 8'd0 : turnsPerSum - 8'd1;
    assign acq_last = (acqSamples == 16'd0) ? 16'd1 : acqSamples;
    assign addr_ok  = {1'b0, loAddr} < ADDR_LIM;

    // Full signed product, round-half-up, keep the top bits.
    function automatic logic [PRODUCT_WIDTH-1:0] round_mul(
        input logic signed [ADC_WIDTH-1:0] a,
        input logic signed [LO_WIDTH-1:0]  b
    );
        logic signed [FULL-1:0] p;
        p = FULL'(a) * FULL'(b);
        p = p + RND;
        return PRODUCT_WIDTH'(p >>> D);
    endfunction

    // LO phase counter and sticky marker-misalignment flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase       <= '0;
            seen_marker <= 1'b0;
            markerError <= 1'b0;
        end else begin
            phase <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + AW'(1);
            if (turnMarker) seen_marker <= 1'b1;
            if (turnMarker && seen_marker && phase != '0)
                markerError <= 1'b1;
            else if (markerClear)
                markerError <= 1'b0;
        end
    end

    // LO table write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (loWrite && addr_ok) begin
            cos_ram[loAddr] <= loCos;
            sin_ram[loAddr] <= loSin;
        end
    end

    // Stage 1: capture sample and read LO (old data on collision).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_adc <= '0;
            s1_cos <= '0;
            s1_sin <= '0;
        end else begin
            s1_adc <= adcData;
            s1_cos <= cos_ram[rd_addr];
            s1_sin <= sin_ram[rd_addr];
        end
    end

    // Window control FSM; registers the stage-1 load/latch flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            turn_cnt   <= '0;
            acq_cnt    <= '0;
            circ_first <= 1'b1;
            s1_load    <= 1'b0;
            s1_latch   <= 1'b0;
        end else begin
            s1_load  <= 1'b0;
            s1_latch <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (singlePass) begin
                        circ_first <= 1'b1;
                        if (trigger) state <= ARMED;
                    end else if (turnMarker) begin
                        if (circ_first || turn_cnt == tps_last) begin
                            s1_load    <= 1'b1;
                            s1_latch   <= 1'b1;
                            turn_cnt   <= '0;
                            circ_first <= 1'b0;
                        end else begin
                            turn_cnt <= turn_cnt + 8'd1;
                        end
                    end
                end
                ARMED: begin
                    if (turnMarker) begin
                        s1_load <= 1'b1;
                        acq_cnt <= 16'd1;
                        state   <= (acq_last == 16'd1) ? LATCH : ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    acq_cnt <= acq_cnt + 16'd1;
                    if (acq_cnt + 16'd1 == acq_last) state <= LATCH;
                end
                LATCH: begin
                    s1_latch <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Stage 2: rounded I/Q products for all four channels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_prod  <= '0;
            s2_load  <= 1'b0;
            s2_latch <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                s2_prod[(2*k)*PRODUCT_WIDTH +: PRODUCT_WIDTH] <=
                    round_mul(s1_adc[k*ADC_WIDTH +: ADC_WIDTH], s1_cos);
                s2_prod[(2*k+1)*PRODUCT_WIDTH +: PRODUCT_WIDTH] <=
                    round_mul(s1_adc[k*ADC_WIDTH +: ADC_WIDTH], s1_sin);
            end
            s2_load  <= s1_load;
            s2_latch <= s1_latch;
        end
    end

    // Stage 3: output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            products    <= '0;
            loadEnable  <= 1'b0;
            latchEnable <= 1'b0;
        end else begin
            products    <= s2_prod;
            loadEnable  <= s2_load;
            latchEnable <= s2_latch;
        end
    end

endmodule

// File: tb/tb_sd_multiply_lo.sv
// Scoreboard bench for sd_multiply_lo: a behavioural model predicts
// every output cycle; a monitor pops and compares on the falling edge.
module tb_sd_multiply_lo;

    localparam int AW  = 16;
    localparam int LW  = 18;
    localparam int PW  = 24;
    localparam int SPT = 81;
    localparam int D   = AW + LW - PW;
    localparam int LA  = $clog2(SPT);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [4*AW-1:0]   adcData;
    logic              turnMarker, singlePass, trigger;
    logic [7:0]        turnsPerSum;
    logic [15:0]       acqSamples;
    logic              loWrite;
    logic [LA-1:0]     loAddr;
    logic [LW-1:0]     loCos, loSin;
    logic              markerClear;
    logic [8*PW-1:0]   products;
    logic              loadEnable, latchEnable, markerError;

    always #5 clk = ~clk;

    sd_multiply_lo #(
        .ADC_WIDTH(AW), .LO_WIDTH(LW),
        .PRODUCT_WIDTH(PW), .SAMPLES_PER_TURN(SPT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .adcData(adcData),
        .turnMarker(turnMarker), .singlePass(singlePass),
        .trigger(trigger), .turnsPerSum(turnsPerSum),
        .acqSamples(acqSamples), .loWrite(loWrite),
        .loAddr(loAddr), .loCos(loCos), .loSin(loSin),
        .markerClear(markerClear), .products(products),
        .loadEnable(loadEnable), .latchEnable(latchEnable),
        .markerError(markerError)
    );

    typedef struct {
        int            due;
        logic [8*PW-1:0] prod;
        logic          ld;
        logic          lt;
    } exp_t;

    typedef struct {
        int   due;
        logic me;
    } mexp_t;

    exp_t  q[$];
    mexp_t mq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // reference model state
    longint m_cos [SPT];
    longint m_sin [SPT];
    int     m_next;
    bit     m_seen, m_merr, m_armed, m_inwin, m_cfirst;
    int     m_wstart, m_wlen, m_msince;

    bit          lo_rand = 0;
    bit          adc_fix = 0;
    logic [63:0] adc_val;

    function automatic logic [PW-1:0] rmul(longint a, longint b);
        longint p;
        p = a * b + (longint'(1) <<< (D - 1));
        p = p >>> D;
        return p[PW-1:0];
    endfunction

    task automatic model_step();
        exp_t  e;
        mexp_t m;
        int    addr, tps, acq;
        bit    set;
        if (!rst_n) begin
            while (q.size() > 0 && q[q.size()-1].due > cyc)
                q.delete(q.size() - 1);
            for (int d = 1; d <= 3; d++) begin
                e.due = cyc + d; e.prod = '0; e.ld = 0; e.lt = 0;
                q.push_back(e);
            end
            m.due = cyc + 1; m.me = 0;
            mq.push_back(m);
            m_next = 0; m_seen = 0; m_merr = 0; m_armed = 0;
            m_inwin = 0; m_cfirst = 1; m_msince = 0;
        end else begin
            tps  = (turnsPerSum == 0) ? 1 : int'(turnsPerSum);
            acq  = (acqSamples == 0) ? 1 : int'(acqSamples);
            addr = turnMarker ? 0 : m_next;
            set  = turnMarker && m_seen && m_next != 0;
            if (turnMarker) m_seen = 1;
            if (set) m_merr = 1;
            else if (markerClear) m_merr = 0;
            m_next = (addr + 1) % SPT;
            for (int k = 0; k < 4; k++) begin
                longint a;
                a = longint'($signed(adcData[k*AW +: AW]));
                e.prod[(2*k)*PW +: PW]   = rmul(a, m_cos[addr]);
                e.prod[(2*k+1)*PW +: PW] = rmul(a, m_sin[addr]);
            end
            e.ld = 0; e.lt = 0;
            if (m_inwin) begin
                if (cyc - m_wstart == m_wlen) begin
                    e.lt = 1; m_inwin = 0;
                end
            end else if (m_armed) begin
                if (turnMarker) begin
                    e.ld = 1; m_armed = 0; m_inwin = 1;
                    m_wstart = cyc; m_wlen = acq;
                end
            end else if (singlePass) begin
                m_cfirst = 1;
                if (trigger) m_armed = 1;
            end else if (turnMarker) begin
                if (m_cfirst || m_msince == tps) begin
                    e.ld = 1; e.lt = 1; m_cfirst = 0; m_msince = 1;
                end else begin
                    m_msince++;
                end
            end
            e.due = cyc + 3;
            q.push_back(e);
            m.due = cyc + 1; m.me = m_merr;
            mq.push_back(m);
        end
        if (loWrite) begin
            m_cos[loAddr] = longint'($signed(loCos));
            m_sin[loAddr] = longint'($signed(loSin));
        end
    endtask

    task automatic cyc_step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_adc();
        adcData = {$urandom(), $urandom()};
        for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 11))
                0: adcData[k*AW +: AW] = 16'h8000;
                1: adcData[k*AW +: AW] = 16'h7fff;
                default: ;
            endcase
        end
        if (adc_fix) adcData = adc_val;
    endtask

    task automatic drive(input bit mk, input bit tr);
        turnMarker = mk;
        trigger    = tr;
        rand_adc();
        if (lo_rand && $urandom_range(0, 7) == 0) begin
            loWrite = 1'b1;
            loAddr  = LA'($urandom_range(0, SPT - 1));
            loCos   = LW'($urandom());
            loSin   = LW'($urandom());
        end else begin
            loWrite = 1'b0;
        end
        cyc_step();
        markerClear = 1'b0;
    endtask

    task automatic fill_table(input int mode);
        for (int a = 0; a < SPT; a++) begin
            turnMarker = 0;
            trigger    = 0;
            rand_adc();
            loWrite = 1'b1;
            loAddr  = LA'(a);
            case (mode)
                0: begin loCos = 18'h1ffff; loSin = 18'h0; end
                1: begin loCos = 18'h20000; loSin = 18'h1ffff; end
                default: begin loCos = LW'($urandom()); loSin = LW'($urandom()); end
            endcase
            cyc_step();
        end
        loWrite = 1'b0;
    endtask

    task automatic run_gap(input int gap, input bit clr);
        for (int i = 0; i < gap; i++) begin
            markerClear = clr && (i == 1);
            drive(i == 0, 1'b0);
        end
    endtask

    // monitor: compare whatever the model expects for this cycle
    always @(negedge clk) begin
        exp_t  e;
        mexp_t m;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            checks++;
            if (products !== e.prod) begin
                errors++;
                $display("FAIL products cyc=%0d got=%h exp=%h",
                         cyc, products, e.prod);
            end
            checks++;
            if (loadEnable !== e.ld) begin
                errors++;
                $display("FAIL loadEnable cyc=%0d got=%b exp=%b",
                         cyc, loadEnable, e.ld);
            end
            checks++;
            if (latchEnable !== e.lt) begin
                errors++;
                $display("FAIL latchEnable cyc=%0d got=%b exp=%b",
                         cyc, latchEnable, e.lt);
            end
        end
        if (mq.size() > 0 && mq[0].due == cyc) begin
            m = mq.pop_front();
            checks++;
            if (markerError !== m.me) begin
                errors++;
                $display("FAIL markerError cyc=%0d got=%b exp=%b",
                         cyc, markerError, m.me);
            end
        end
    end

    initial begin
        int steps;
        rst_n = 0; turnMarker = 0; singlePass = 0; trigger = 0;
        turnsPerSum = 8'd4; acqSamples = 16'd10; loWrite = 0;
        loAddr = '0; loCos = '0; loSin = '0; markerClear = 0;
        adcData = '0; adc_val = '0;
        for (int a = 0; a < SPT; a++) begin
            m_cos[a] = 0; m_sin[a] = 0;
        end
        @(posedge clk);
        #1;
        repeat (3) drive(1'b0, 1'b0);
        rst_n = 1;

        // cos = 2^17-1, sin = 0; channel 0 fixed at 1000
        fill_table(0);
        adc_fix = 1;
        adc_val = {16'd5, 16'hffff, 16'h8000, 16'd1000};
        repeat (6) drive(1'b0, 1'b0);
        adc_fix = 0;

        // most-negative sample times most-negative cos
        fill_table(1);
        adc_fix = 1;
        adc_val = {4{16'h8000}};
        repeat (6) drive(1'b0, 1'b0);
        adc_fix = 0;

        // circular mode, 4 turns per sum, live LO updates
        fill_table(2);
        lo_rand = 1;
        repeat (8) run_gap(81, 1'b0);
        singlePass = 1;
        repeat (2) drive(1'b0, 1'b0);
        singlePass = 0;
        turnsPerSum = 8'd0;
        repeat (4) run_gap(81, 1'b0);

        // misaligned marker then clear
        run_gap(81, 1'b0);
        run_gap(80, 1'b0);
        run_gap(30, 1'b0);
        run_gap(81, 1'b0);
        run_gap(81, 1'b1);
        repeat (3) run_gap(81, 1'b0);

        // single-pass directed window with ignored re-trigger
        singlePass = 1;
        acqSamples = 16'd10;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        repeat (5) drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        repeat (4) drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        repeat (20) drive(1'b0, 1'b0);

        // trigger and marker together only arm
        acqSamples = 16'd3;
        drive(1'b1, 1'b1);
        repeat (3) drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        repeat (8) drive(1'b0, 1'b0);

        // random windows, singlePass toggled mid-window
        for (int w = 0; w < 12; w++) begin
            singlePass = 1;
            case (w % 4)
                0: acqSamples = 16'd0;
                1: acqSamples = 16'd1;
                2: acqSamples = 16'd2;
                default: acqSamples = 16'($urandom_range(3, 40));
            endcase
            drive(1'b0, 1'b1);
            steps = 0;
            while ((m_armed || m_inwin) && steps < 400) begin
                singlePass = ($urandom_range(0, 3) != 0);
                drive($urandom_range(0, 15) == 0,
                      $urandom_range(0, 20) == 0);
                steps++;
            end
            checks++;
            if (m_armed || m_inwin) begin
                errors++;
                $display("FAIL window_timeout w=%0d got=%0d exp=<400",
                         w, steps);
            end
        end

        // reset during an acquisition
        singlePass = 1;
        acqSamples = 16'd30;
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        repeat (5) drive(1'b0, 1'b0);
        rst_n = 0;
        drive(1'b0, 1'b0);
        rst_n = 1;
        repeat (40) drive(1'b0, 1'b0);

        // back to circular, first marker after reset
        singlePass = 0;
        turnsPerSum = 8'd2;
        run_gap(50, 1'b0);
        repeat (5) run_gap(81, 1'b0);

        lo_rand = 0;
        turnMarker = 0;
        trigger = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0 || mq.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0", q.size() + mq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
